// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: operand width and the Montgomery FSM state type.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mont_state_t;

endpackage

// File: rtl/montgomery_mult_if.sv
// Request/response bundle between the exponentiation controller and the Montgomery multiplier.
interface montgomery_mult_if
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
);

  logic             i_valid;
  logic [WIDTH-1:0] i_N;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] o_montgomery;
  logic             o_ready;

  modport master (
    output i_valid, i_N, i_a, i_b,
    input  o_montgomery, o_ready
  );

  modport slave (
    input  i_valid, i_N, i_a, i_b,
    output o_montgomery, o_ready
  );

endinterface

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: m' = (m + a_bit*b + q*N) / 2, q chosen to make the sum even.
module mont_step
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH+1:0] m,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] next_m_c
);

  localparam int unsigned MW = WIDTH + 2;

  logic [MW-1:0] add_b_c;
  logic [MW-1:0] add_n_c;

  // m < 2N and b, N < 2^WIDTH keep every partial sum below 2^(WIDTH+2)
  always_comb begin
    add_b_c  = m + (a_bit ? {2'b00, b} : '0);
    add_n_c  = add_b_c + (add_b_c[0] ? {2'b00, n} : '0);
    next_m_c = add_n_c >> 1;
  end

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod N after WIDTH+1 cycles.
module montgomery_mult
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  montgomery_mult_if.slave bus
);

  localparam int unsigned MW    = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  mont_state_t      state_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [MW-1:0]    m_q;
  logic [MW-1:0]    m_next_c;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;

  mont_step #(.WIDTH(WIDTH)) u_step (
    .m        (m_q),
    .a_bit    (a_q[cnt_q]),
    .b        (b_q),
    .n        (n_q),
    .next_m_c (m_next_c)
  );

  // Operands are latched at start so the requester may move on immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            n_q     <= bus.i_N;
            a_q     <= bus.i_a;
            b_q     <= bus.i_b;
            m_q     <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          m_q   <= m_next_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Final conditional subtraction brings m from [0, 2N) into [0, N)
          result_q <= (m_q >= {2'b00, n_q}) ? WIDTH'(m_q - {2'b00, n_q}) : WIDTH'(m_q);
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_montgomery = result_q;
  assign bus.o_ready      = ready_q;

endmodule

// File: tb/tb_montgomery_mult.sv
// Directed and randomized checks of montgomery_mult against a modular-arithmetic reference.
module tb_montgomery_mult;
  import rsa_pkg::*;

  localparam int unsigned W   = RSA_WIDTH;
  localparam int          LAT = W + 1;

  logic clk = 1'b0;
  logic rst;

  montgomery_mult_if #(.WIDTH(W)) bus ();

  montgomery_mult #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] nxt_n, nxt_a, nxt_b;

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int k = 0; k < int'(W / 32); k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // a*R mod N, the form ModuloProduct hands to this block
  function automatic logic [W-1:0] to_mont(input logic [W-1:0] n, input logic [W-1:0] a);
    logic [2*W-1:0] p;
    p = ((2*W)'(a) << W) % (2*W)'(n);
    return p[W-1:0];
  endfunction

  // a*b*2^-W mod N: reduce the full product, then halve W times modulo odd N
  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] n, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W:0]     x;
    p = ((2*W)'(a) * (2*W)'(b)) % (2*W)'(n);
    x = (W+1)'(p);
    for (int k = 0; k < int'(W); k++) x = x[0] ? ((x + (W+1)'(n)) >> 1) : (x >> 1);
    return x[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bus.i_N = rand_w();
    bus.i_a = rand_w();
    bus.i_b = rand_w();
  endtask

  task automatic start(input logic [W-1:0] n, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.i_N     = n;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    scramble();
  endtask

  // Observe up to max_k edges after a start edge; optional busy strobe, reset, or chained start
  task automatic watch(input int max_k, input int busy_at, input int rst_at, input bit chain,
                       output int ready_at, output int ready_cnt, output logic [W-1:0] val);
    ready_at  = -1;
    ready_cnt = 0;
    val       = '0;
    for (int k = 1; k <= max_k; k++) begin
      @(posedge clk);
      #1;
      if (k == busy_at + 1) bus.i_valid = 1'b0;
      if (bus.o_ready === 1'b1) begin
        ready_cnt++;
        if (ready_at < 0) begin
          ready_at = k;
          val      = bus.o_montgomery;
        end
        if (chain) begin
          bus.i_N     = nxt_n;
          bus.i_a     = nxt_a;
          bus.i_b     = nxt_b;
          bus.i_valid = 1'b1;
          @(posedge clk);
          #1;
          bus.i_valid = 1'b0;
          scramble();
          return;
        end
      end
      if (k == busy_at) begin
        scramble();
        bus.i_valid = 1'b1;
      end
      if (k == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ready", W'(bus.o_ready), '0);
        check("rst_async_result", bus.o_montgomery, '0);
        #2;
        rst = 1'b0;
      end
    end
  endtask

  task automatic check_op(input string tag, input int ready_at, input int ready_cnt,
                          input logic [W-1:0] val, input logic [W-1:0] exp);
    check({tag, "_latency"}, W'(ready_at), W'(LAT));
    check({tag, "_pulses"}, W'(ready_cnt), W'(1));
    check({tag, "_value"}, val, exp);
  endtask

  initial begin
    logic [W-1:0] n, a, b, nf;
    int ra, rc;
    logic [W-1:0] v;

    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_N     = '0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    #12;
    check("reset_ready", W'(bus.o_ready), '0);
    check("reset_result", bus.o_montgomery, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Chained small modulus: 1000 * 1000 mod 18795
    n = W'(18795);
    start(n, W'(1000), to_mont(n, W'(1000)));
    watch(262, -1, -1, 1'b0, ra, rc, v);
    check_op("chain_small", ra, rc, v, W'(3865));

    // Identity and zero
    start(n, W'(1), to_mont(n, W'(1)));
    watch(262, -1, -1, 1'b0, ra, rc, v);
    check_op("identity_one", ra, rc, v, W'(1));
    start(n, '0, W'(12345));
    watch(262, -1, -1, 1'b0, ra, rc, v);
    check_op("identity_zero", ra, rc, v, '0);

    // Full-width modulus 2^256 - 189 with a = N - 1
    nf = '1;
    nf = nf - W'(188);
    start(nf, nf - W'(1), to_mont(nf, nf - W'(1)));
    watch(262, -1, -1, 1'b0, ra, rc, v);
    check_op("full_width", ra, rc, v, W'(1));

    // Busy strobe ignored, then back-to-back start in the o_ready cycle
    start(n, W'(1000), to_mont(n, W'(1000)));
    nxt_n = nf;
    nxt_a = nf - W'(1);
    nxt_b = to_mont(nf, nf - W'(1));
    watch(262, 100, -1, 1'b1, ra, rc, v);
    check_op("busy_ignored", ra, rc, v, W'(3865));
    watch(262, -1, -1, 1'b0, ra, rc, v);
    check_op("back_to_back", ra, rc, v, W'(1));

    // Asynchronous reset mid-operation discards it
    start(n, W'(1234), to_mont(n, W'(4321)));
    watch(262, -1, 120, 1'b0, ra, rc, v);
    check("rst_no_ready", W'(rc), '0);
    start(n, W'(1000), to_mont(n, W'(1000)));
    watch(262, -1, -1, 1'b0, ra, rc, v);
    check_op("after_reset", ra, rc, v, W'(3865));

    // Random regression against the reference model
    for (int t = 0; t < 150; t++) begin
      n = rand_w();
      n[0] = 1'b1;
      if (t % 2 == 1) n[W-1] = 1'b1;
      if (t % 5 == 0) n = n >> ($urandom_range(W - 16));
      n[0] = 1'b1;
      if (n < W'(3)) n = W'(3);
      a = rand_w() % n;
      b = rand_w() % n;
      start(n, a, b);
      watch(258, -1, -1, 1'b0, ra, rc, v);
      check_op("random", ra, rc, v, mont_ref(n, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
